apb_decode_n: RTL and testbench

- Parametrised APB fan-out decoder. One upstream APB completer port, N_TGT downstream APB requester ports.
- Routes each transaction by the top ID_W address bits (instance address ID). Registers the request, forwards it with the ID field cleared, and returns the response upstream.
- Adds what the fixed two-target decoder lacks:
  - any target count;
  - PSLVERR for unmapped IDs;
  - per-transaction timeout with error reporting.
- Sits between the top-level APB master and the per-instance register/memory blocks.

---
 rtl/apb_decode_n.sv | 183 ++++++++++++++++++
 tb/tb_apb_decode_n.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_decode_n.sv
// rtl/apb_decode_n.sv - APB fan-out decoder routing by top address ID bits to N_TGT targets
//
// Purpose: one upstream APB completer port fanned out to N_TGT downstream
// APB requester ports. The top ID_W address bits select the target. The ID
// field is cleared on the forwarded address. Unmapped IDs are rejected with
// PSLVERR. A stalled access is aborted after TIMEOUT_CYC ACCESS cycles.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   s_psel/s_penable/s_pwrite       upstream control
//   s_paddr/s_pwdata                upstream address / write data
//   s_pready/s_prdata/s_pslverr     upstream response (registered, one-cycle pulse)
//   m_psel[N_TGT]                   one-hot downstream select
//   m_penable/m_pwrite              shared downstream control
//   m_paddr/m_pwdata                shared downstream address (ID cleared) / data
//   m_pready/m_prdata/m_pslverr     per-target response, target i at slice i
//   err_timeout/err_unmapped        one-cycle error event pulses
module apb_decode_n #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int N_TGT       = 2,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    s_psel,
  input  logic                    s_penable,
  input  logic                    s_pwrite,
  input  logic [ADDR_W-1:0]       s_paddr,
  input  logic [DATA_W-1:0]       s_pwdata,
  output logic                    s_pready,
  output logic [DATA_W-1:0]       s_prdata,
  output logic                    s_pslverr,
  output logic [N_TGT-1:0]        m_psel,
  output logic                    m_penable,
  output logic                    m_pwrite,
  output logic [ADDR_W-1:0]       m_paddr,
  output logic [DATA_W-1:0]       m_pwdata,
  input  logic [N_TGT-1:0]        m_pready,
  input  logic [N_TGT*DATA_W-1:0] m_prdata,
  input  logic [N_TGT-1:0]        m_pslverr,
  output logic                    err_timeout,
  output logic                    err_unmapped
);

  localparam int ID_W  = $clog2(N_TGT);
  localparam int CNT_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [ID_W:0]     N_TGT_V  = (ID_W + 1)'(N_TGT);
  localparam logic [ADDR_W-1:0] ID_MASK  = {{ID_W{1'b1}}, {(ADDR_W - ID_W){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [ID_W-1:0]    r_id;
  logic               r_write;

  logic [ID_W-1:0]    w_req_id;
  logic               w_mapped;
  logic               w_cap;
  logic [ID_W-1:0]    w_id_nxt;
  logic               w_sel_ready;
  logic               w_sel_err;
  logic [DATA_W-1:0]  w_sel_rdata;
  logic               w_resp_load;
  logic [DATA_W-1:0]  w_resp_rdata;
  logic               w_resp_err;
  logic               w_unm;
  logic               w_to;
  logic [N_TGT-1:0]   w_psel_nxt;

  assign w_req_id = s_paddr[ADDR_W-1 -: ID_W];
  assign w_mapped = ({1'b0, w_req_id} < N_TGT_V);
  assign w_id_nxt = w_cap ? w_req_id : r_id;

  // Response mux for the captured target; other targets' ready bits never matter.
  always_comb begin
    w_sel_ready = 1'b0;
    w_sel_err   = 1'b0;
    w_sel_rdata = '0;
    for (int i = 0; i < N_TGT; i++) begin
      if (r_id == ID_W'(i)) begin
        w_sel_ready = m_pready[i];
        w_sel_err   = m_pslverr[i];
        w_sel_rdata = m_prdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cap        = 1'b0;
    w_resp_load  = 1'b0;
    w_resp_rdata = '0;
    w_resp_err   = 1'b0;
    w_unm        = 1'b0;
    w_to         = 1'b0;
    case (r_state)
      S_IDLE: begin
        // Only a proper setup phase starts a transfer; psel&penable here is ignored.
        if (s_psel && !s_penable) begin
          w_cap = 1'b1;
          if (w_mapped) begin
            w_state_nxt = S_SETUP;
          end else begin
            w_state_nxt = S_RESP;
            w_resp_load = 1'b1;
            w_resp_err  = 1'b1;
            w_unm       = 1'b1;
          end
        end
      end
      S_SETUP: w_state_nxt = S_ACCESS;
      S_ACCESS: begin
        if (w_sel_ready) begin
          w_state_nxt  = S_RESP;
          w_resp_load  = 1'b1;
          w_resp_rdata = r_write ? '0 : w_sel_rdata;
          w_resp_err   = w_sel_err;
        end else if ((TIMEOUT_CYC != 0) && (r_cnt == CNT_LAST)) begin
          w_state_nxt = S_RESP;
          w_resp_load = 1'b1;
          w_resp_err  = 1'b1;
          w_to        = 1'b1;
        end
      end
      S_RESP: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_comb begin
    w_psel_nxt = '0;
    if ((w_state_nxt == S_SETUP) || (w_state_nxt == S_ACCESS)) begin
      for (int i = 0; i < N_TGT; i++) begin
        if (w_id_nxt == ID_W'(i)) w_psel_nxt[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_id         <= '0;
      r_write      <= 1'b0;
      m_psel       <= '0;
      m_penable    <= 1'b0;
      m_pwrite     <= 1'b0;
      m_paddr      <= '0;
      m_pwdata     <= '0;
      s_pready     <= 1'b0;
      s_prdata     <= '0;
      s_pslverr    <= 1'b0;
      err_timeout  <= 1'b0;
      err_unmapped <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= ((r_state == S_ACCESS) && (w_state_nxt == S_ACCESS)) ? r_cnt + 1'b1 : '0;
      if (w_cap) begin
        r_id    <= w_req_id;
        r_write <= s_pwrite;
      end
      // Downstream bus only changes for mapped transfers.
      if (w_cap && w_mapped) begin
        m_paddr  <= s_paddr & ~ID_MASK;
        m_pwdata <= s_pwdata;
        m_pwrite <= s_pwrite;
      end
      m_psel       <= w_psel_nxt;
      m_penable    <= (w_state_nxt == S_ACCESS);
      s_pready     <= w_resp_load;
      s_prdata     <= w_resp_rdata;
      s_pslverr    <= w_resp_err;
      err_timeout  <= w_to;
      err_unmapped <= w_unm;
    end
  end

endmodule

// File: tb/tb_apb_decode_n.sv
// tb/tb_apb_decode_n.sv - self-checking bench for apb_decode_n
module tb_apb_decode_n;

  logic        clk;
  logic        rst_n;
  logic        s_psel, s_penable, s_pwrite, use3;
  logic [31:0] s_paddr, s_pwdata;
  logic        s_psel_a, s_psel_b;

  logic        s_pready_a, s_pslverr_a, m_penable_a, m_pwrite_a, err_timeout_a, err_unmapped_a;
  logic [31:0] s_prdata_a, m_paddr_a, m_pwdata_a;
  logic [1:0]  m_psel_a, m_pready_a, m_pslverr_a;
  logic [63:0] m_prdata_a;

  logic        s_pready_b, s_pslverr_b, m_penable_b, m_pwrite_b, err_timeout_b, err_unmapped_b;
  logic [31:0] s_prdata_b, m_paddr_b, m_pwdata_b;
  logic [2:0]  m_psel_b, m_pready_b, m_pslverr_b;
  logic [95:0] m_prdata_b;

  logic [31:0] tgt_rdata [2];
  int          tgt_wait  [2];
  logic        tgt_err   [2];
  logic        tgt_never [2];
  logic        tgt_force [2];
  int          acc_cnt   [2];

  int n_chk = 0;
  int n_err = 0;

  assign s_psel_a    = s_psel & ~use3;
  assign s_psel_b    = s_psel & use3;
  assign m_prdata_a  = {tgt_rdata[1], tgt_rdata[0]};
  assign m_pslverr_a = {tgt_err[1], tgt_err[0]};
  assign m_pready_b  = 3'b111;
  assign m_prdata_b  = {32'h3333_0002, 32'h3333_0001, 32'h3333_0000};
  assign m_pslverr_b = 3'b000;

  apb_decode_n #(.ADDR_W(32), .DATA_W(32), .N_TGT(2), .TIMEOUT_CYC(16)) u_dut2 (
    .clk(clk), .rst_n(rst_n),
    .s_psel(s_psel_a), .s_penable(s_penable), .s_pwrite(s_pwrite),
    .s_paddr(s_paddr), .s_pwdata(s_pwdata),
    .s_pready(s_pready_a), .s_prdata(s_prdata_a), .s_pslverr(s_pslverr_a),
    .m_psel(m_psel_a), .m_penable(m_penable_a), .m_pwrite(m_pwrite_a),
    .m_paddr(m_paddr_a), .m_pwdata(m_pwdata_a),
    .m_pready(m_pready_a), .m_prdata(m_prdata_a), .m_pslverr(m_pslverr_a),
    .err_timeout(err_timeout_a), .err_unmapped(err_unmapped_a)
  );

  apb_decode_n #(.ADDR_W(32), .DATA_W(32), .N_TGT(3), .TIMEOUT_CYC(16)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .s_psel(s_psel_b), .s_penable(s_penable), .s_pwrite(s_pwrite),
    .s_paddr(s_paddr), .s_pwdata(s_pwdata),
    .s_pready(s_pready_b), .s_prdata(s_prdata_b), .s_pslverr(s_pslverr_b),
    .m_psel(m_psel_b), .m_penable(m_penable_b), .m_pwrite(m_pwrite_b),
    .m_paddr(m_paddr_b), .m_pwdata(m_pwdata_b),
    .m_pready(m_pready_b), .m_prdata(m_prdata_b), .m_pslverr(m_pslverr_b),
    .err_timeout(err_timeout_b), .err_unmapped(err_unmapped_b)
  );

  // Upstream view of whichever instance is addressed.
  wire        u_pready  = use3 ? s_pready_b     : s_pready_a;
  wire [31:0] u_prdata  = use3 ? s_prdata_b     : s_prdata_a;
  wire        u_pslverr = use3 ? s_pslverr_b    : s_pslverr_a;
  wire [2:0]  u_psel    = use3 ? m_psel_b       : {1'b0, m_psel_a};
  wire        u_penable = use3 ? m_penable_b    : m_penable_a;
  wire        u_pwrite  = use3 ? m_pwrite_b     : m_pwrite_a;
  wire [31:0] u_paddr   = use3 ? m_paddr_b      : m_paddr_a;
  wire [31:0] u_pwdata  = use3 ? m_pwdata_b     : m_pwdata_a;
  wire        u_err_to  = use3 ? err_timeout_b  : err_timeout_a;
  wire        u_err_unm = use3 ? err_unmapped_b : err_unmapped_a;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream target model for the two-target instance.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (m_psel_a[i] && m_penable_a) begin
        m_pready_a[i] <= tgt_force[i] | (!tgt_never[i] && (acc_cnt[i] == tgt_wait[i]));
        acc_cnt[i]    <= acc_cnt[i] + 1;
      end else begin
        m_pready_a[i] <= tgt_force[i];
        acc_cnt[i]    <= 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input int budget, output int lat, output logic [31:0] rdata,
                      output logic err, output logic [2:0] sel_or, output logic [31:0] paddr,
                      output logic [31:0] pwdata, output logic pwrite, output int pen_cnt,
                      output int n_unm, output int n_to, output int leak);
    lat = 0; rdata = '0; err = 1'b0; sel_or = '0; paddr = '0; pwdata = '0; pwrite = 1'b0;
    pen_cnt = 0; n_unm = 0; n_to = 0; leak = 0;
    @(negedge clk);
    s_psel = 1'b1; s_penable = 1'b0; s_pwrite = wr; s_paddr = addr; s_pwdata = wdata;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      if (c == 1) s_penable = 1'b1;
      sel_or = sel_or | u_psel;
      if (u_psel != 3'b000) begin
        paddr = u_paddr; pwdata = u_pwdata; pwrite = u_pwrite;
      end
      if (u_penable) pen_cnt++;
      if (u_err_unm) n_unm++;
      if (u_err_to) n_to++;
      if (!u_pready && (u_prdata != 32'h0)) leak++;
      if (u_pready) begin
        lat = c; rdata = u_prdata; err = u_pslverr;
        break;
      end
    end
    @(posedge clk);
    #1;
    s_psel = 1'b0; s_penable = 1'b0;
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          wait_n;
    logic [31:0] trdata;
    logic        terr;
    logic        oth_rdy;
    logic [2:0]  exp_sel;
    logic [31:0] exp_paddr;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs [5];

  int          lat, pen_cnt, n_unm, n_to, leak, t, cnt;
  logic [31:0] rdata, paddr, pwdata;
  logic        err, pwrite;
  logic [2:0]  sel_or;

  initial begin
    vecs[0] = '{1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 0, 32'hAAAA_5555, 1'b0, 1'b0,
                3'b010, 32'h0000_0010, 32'h0, 1'b0, 3};
    vecs[1] = '{1'b0, 32'h0000_0004, 32'h0, 3, 32'h1234_5678, 1'b0, 1'b0,
                3'b001, 32'h0000_0004, 32'h1234_5678, 1'b0, 6};
    vecs[2] = '{1'b0, 32'h8000_0100, 32'h0, 1, 32'hCAFE_F00D, 1'b1, 1'b1,
                3'b010, 32'h0000_0100, 32'hCAFE_F00D, 1'b1, 4};
    vecs[3] = '{1'b1, 32'h7FFF_FFFC, 32'h0BAD_CAFE, 2, 32'h5555_AAAA, 1'b1, 1'b1,
                3'b001, 32'h7FFF_FFFC, 32'h0, 1'b1, 5};
    vecs[4] = '{1'b0, 32'hFFFF_FFF0, 32'h0, 0, 32'h0000_0001, 1'b0, 1'b0,
                3'b010, 32'h7FFF_FFF0, 32'h0000_0001, 1'b0, 3};

    rst_n = 1'b0; use3 = 1'b0;
    s_psel = 1'b0; s_penable = 1'b0; s_pwrite = 1'b0; s_paddr = '0; s_pwdata = '0;
    for (int i = 0; i < 2; i++) begin
      tgt_rdata[i] = '0; tgt_wait[i] = 0; tgt_err[i] = 1'b0;
      tgt_never[i] = 1'b0; tgt_force[i] = 1'b0;
    end

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_resp", longint'({s_pready_a, s_pslverr_a, err_timeout_a, err_unmapped_a}), 0);
    chk("rst_prdata", longint'(s_prdata_a), 0);
    chk("rst_mctl", longint'({m_psel_a, m_penable_a, m_pwrite_a}), 0);
    chk("rst_maddr", longint'(m_paddr_a), 0);
    chk("rst_mwdata", longint'(m_pwdata_a), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven transfers on the two-target instance, back to back.
    for (int v = 0; v < 5; v++) begin
      t = int'(vecs[v].addr[31]);
      tgt_wait[0] = vecs[v].wait_n; tgt_wait[1] = vecs[v].wait_n;
      tgt_rdata[t] = vecs[v].trdata; tgt_rdata[1-t] = 32'hBAD0_0000 | v;
      tgt_err[t] = vecs[v].terr; tgt_err[1-t] = 1'b0;
      tgt_force[t] = 1'b0; tgt_force[1-t] = vecs[v].oth_rdy;
      xfer(vecs[v].wr, vecs[v].addr, vecs[v].wdata, 40, lat, rdata, err, sel_or,
           paddr, pwdata, pwrite, pen_cnt, n_unm, n_to, leak);
      chk($sformatf("v%0d_lat", v), longint'(lat), longint'(vecs[v].exp_lat));
      chk($sformatf("v%0d_rdata", v), longint'(rdata), longint'(vecs[v].exp_rdata));
      chk($sformatf("v%0d_err", v), longint'(err), longint'(vecs[v].exp_err));
      chk($sformatf("v%0d_sel", v), longint'(sel_or), longint'(vecs[v].exp_sel));
      chk($sformatf("v%0d_paddr", v), longint'(paddr), longint'(vecs[v].exp_paddr));
      chk($sformatf("v%0d_pwrite", v), longint'(pwrite), longint'(vecs[v].wr));
      if (vecs[v].wr) chk($sformatf("v%0d_pwdata", v), longint'(pwdata), longint'(vecs[v].wdata));
      chk($sformatf("v%0d_penable_cyc", v), longint'(pen_cnt), longint'(vecs[v].wait_n + 1));
      chk($sformatf("v%0d_errpulses", v), longint'(n_unm + n_to), 0);
      chk($sformatf("v%0d_prdata_idle", v), longint'(leak), 0);
    end
    tgt_force[0] = 1'b0; tgt_force[1] = 1'b0;

    // Three-target instance: unmapped ID 3, then mapped IDs 2 and 1.
    use3 = 1'b1;
    xfer(1'b0, 32'hC000_0000, 32'h0, 10, lat, rdata, err, sel_or,
         paddr, pwdata, pwrite, pen_cnt, n_unm, n_to, leak);
    chk("unm_lat", longint'(lat), 1);
    chk("unm_err", longint'(err), 1);
    chk("unm_rdata", longint'(rdata), 0);
    chk("unm_sel", longint'(sel_or), 0);
    chk("unm_penable", longint'(pen_cnt), 0);
    chk("unm_pulse", longint'(n_unm), 1);
    chk("unm_to_pulse", longint'(n_to), 0);
    xfer(1'b1, 32'h8000_0020, 32'h0000_5A5A, 10, lat, rdata, err, sel_or,
         paddr, pwdata, pwrite, pen_cnt, n_unm, n_to, leak);
    chk("id2_lat", longint'(lat), 3);
    chk("id2_sel", longint'(sel_or), 3'b100);
    chk("id2_paddr", longint'(paddr), 32'h0000_0020);
    chk("id2_pwdata", longint'(pwdata), 32'h0000_5A5A);
    chk("id2_err", longint'({err, n_unm[0]}), 0);
    xfer(1'b0, 32'h4000_0008, 32'h0, 10, lat, rdata, err, sel_or,
         paddr, pwdata, pwrite, pen_cnt, n_unm, n_to, leak);
    chk("id1_rdata", longint'(rdata), 32'h3333_0001);
    chk("id1_sel", longint'(sel_or), 3'b010);
    chk("id1_paddr", longint'(paddr), 32'h0000_0008);
    use3 = 1'b0;

    // Timeout: target 0 never ready.
    tgt_never[0] = 1'b1; tgt_err[0] = 1'b0; tgt_rdata[0] = 32'h7777_7777;
    xfer(1'b0, 32'h0000_0008, 32'h0, 40, lat, rdata, err, sel_or,
         paddr, pwdata, pwrite, pen_cnt, n_unm, n_to, leak);
    chk("to_lat", longint'(lat), 18);
    chk("to_penable", longint'(pen_cnt), 16);
    chk("to_err", longint'(err), 1);
    chk("to_rdata", longint'(rdata), 0);
    chk("to_pulse", longint'(n_to), 1);
    chk("to_unm_pulse", longint'(n_unm), 0);
    // Late ready from target 0 after the abort must not produce a response.
    tgt_force[0] = 1'b1;
    cnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (s_pready_a || (m_psel_a != 2'b00) || err_timeout_a) cnt++;
    end
    chk("late_ready_ignored", longint'(cnt), 0);
    tgt_force[0] = 1'b0; tgt_never[0] = 1'b0; tgt_wait[0] = 0; tgt_rdata[0] = 32'h0F0F_0F0F;
    xfer(1'b0, 32'h0000_000C, 32'h0, 40, lat, rdata, err, sel_or,
         paddr, pwdata, pwrite, pen_cnt, n_unm, n_to, leak);
    chk("post_to_lat", longint'(lat), 3);
    chk("post_to_rdata", longint'(rdata), 32'h0F0F_0F0F);
    chk("post_to_err", longint'(err), 0);

    // Asynchronous reset during ACCESS.
    tgt_never[0] = 1'b1;
    @(negedge clk);
    s_psel = 1'b1; s_penable = 1'b0; s_pwrite = 1'b1; s_paddr = 32'h0000_0030; s_pwdata = 32'h1;
    @(negedge clk);
    s_penable = 1'b1;
    @(negedge clk);
    chk("rst_pre_access", longint'({m_psel_a, m_penable_a}), 3'b011);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_mctl", longint'({m_psel_a, m_penable_a}), 0);
    chk("rst_async_pready", longint'(s_pready_a), 0);
    s_psel = 1'b0; s_penable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (s_pready_a || (m_psel_a != 2'b00)) cnt++;
    end
    chk("rst_no_resp", longint'(cnt), 0);
    tgt_never[0] = 1'b0; tgt_wait[0] = 0;
    xfer(1'b1, 32'h0000_0040, 32'h1111_2222, 40, lat, rdata, err, sel_or,
         paddr, pwdata, pwrite, pen_cnt, n_unm, n_to, leak);
    chk("post_rst_lat", longint'(lat), 3);
    chk("post_rst_sel", longint'(sel_or), 3'b001);
    chk("post_rst_pwdata", longint'(pwdata), 32'h1111_2222);
    chk("post_rst_err", longint'(err), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
